// File: rtl/mem_stage_ctrl_pkg.sv
// Shared state encodings and defaults for the MEM-stage data-memory sequencer.
package mem_stage_ctrl_pkg;

  localparam int MSC_DW      = 32;
  localparam int MSC_AW      = 32;
  localparam int MSC_TIMEOUT = 16;
  localparam int MSC_CNT_W   = 5;

  localparam logic RESET_ENABLE_N = 1'b0;

  typedef enum logic [1:0] {
    MSC_IDLE = 2'd0,
    MSC_REQ  = 2'd1,
    MSC_RESP = 2'd2,
    MSC_DONE = 2'd3
  } msc_state_e;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Purpose: wait-cycle counter for the data-memory sequencer, flags expiry at TIMEOUT-1.
// Latency: expire_o is combinational on the registered count.
// Backpressure: none; the owner clears it on state entry and enables it while waiting.
module mem_timeout_cnt
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = MSC_TIMEOUT,
  parameter int CNT_W   = MSC_CNT_W
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (rst_i == RESET_ENABLE_N) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire_o = en_i & (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// Purpose: runs the req/gnt/rvalid data-memory access for the EX/MEM instruction.
// Latency: store 2 stall cycles, load 3 stall cycles with immediate gnt/rvalid.
// Backpressure: stall_o freezes upstream stage registers until DONE; timeout ends the wait.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int DW      = MSC_DW,
  parameter int AW      = MSC_AW,
  parameter int TIMEOUT = MSC_TIMEOUT,
  parameter int CNT_W   = MSC_CNT_W
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          mem_valid_i,
  input  logic          mem_rd_i,
  input  logic          MemRW_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          flush_i,
  output logic          dmem_req_o,
  output logic          dmem_we_o,
  output logic [AW-1:0] dmem_addr_o,
  output logic [DW-1:0] dmem_wdata_o,
  input  logic          dmem_gnt_i,
  input  logic          dmem_rvalid_i,
  input  logic [DW-1:0] dmem_rdata_i,
  output logic          stall_o,
  output logic [DW-1:0] rdata_o,
  output logic          rdata_valid_o,
  output logic          err_o
);

  msc_state_e state_q, state_d;
  logic       access;
  logic       flushed_q;
  logic       err_q;
  logic       cnt_clr;
  logic       cnt_en;
  logic       expire;

  assign access = mem_valid_i & (mem_rd_i | MemRW_i) & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (rst_i == RESET_ENABLE_N) begin
      state_q <= MSC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    stall_o       = 1'b0;
    dmem_req_o    = 1'b0;
    rdata_valid_o = 1'b0;
    err_o         = 1'b0;
    case (state_q)
      MSC_IDLE: begin
        if (access) begin
          stall_o = 1'b1;
          state_d = MSC_REQ;
        end
      end
      MSC_REQ: begin
        stall_o    = 1'b1;
        dmem_req_o = 1'b1;
        // A grant wins over flush and timeout: the memory has already taken the access.
        if (dmem_gnt_i) begin
          state_d = dmem_we_o ? MSC_DONE : MSC_RESP;
        end else if (flush_i) begin
          state_d = MSC_IDLE;
        end else if (expire) begin
          state_d = MSC_DONE;
        end
      end
      MSC_RESP: begin
        stall_o = 1'b1;
        if (dmem_rvalid_i || expire) begin
          state_d = MSC_DONE;
        end
      end
      MSC_DONE: begin
        rdata_valid_o = ~dmem_we_o & ~flushed_q & ~err_q;
        err_o         = err_q;
        state_d       = MSC_IDLE;
      end
      default: state_d = MSC_IDLE;
    endcase
  end

  // Count restarts on every state change so REQ and RESP each get a full budget.
  assign cnt_clr = (state_d != state_q);
  assign cnt_en  = (state_q == MSC_REQ) || (state_q == MSC_RESP);

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .expire_o (expire)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (rst_i == RESET_ENABLE_N) begin
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      rdata_o      <= '0;
      flushed_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        MSC_IDLE: begin
          if (access) begin
            dmem_addr_o  <= addr_i;
            dmem_wdata_o <= wdata_i;
            dmem_we_o    <= MemRW_i;
            flushed_q    <= 1'b0;
            err_q        <= 1'b0;
          end
        end
        MSC_REQ: begin
          if (flush_i) begin
            flushed_q <= 1'b1;
          end
          if (!dmem_gnt_i && !flush_i && expire) begin
            err_q   <= 1'b1;
            rdata_o <= '0;
          end
        end
        MSC_RESP: begin
          if (flush_i) begin
            flushed_q <= 1'b1;
          end
          if (dmem_rvalid_i) begin
            if (!(flushed_q || flush_i)) begin
              rdata_o <= dmem_rdata_i;
            end
          end else if (expire) begin
            err_q   <= 1'b1;
            rdata_o <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: inputs change and outputs are sampled on the falling edge.
module tb_mem_stage_ctrl;

  logic        clk_i;
  logic        rst_i;
  logic        mem_valid_i;
  logic        mem_rd_i;
  logic        MemRW_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        flush_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        err_o;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .mem_valid_i   (mem_valid_i),
    .mem_rd_i      (mem_rd_i),
    .MemRW_i       (MemRW_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .flush_i       (flush_i),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .stall_o       (stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .err_o         (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic next_cycle();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    mem_valid_i   = 1'b0;
    mem_rd_i      = 1'b0;
    MemRW_i       = 1'b0;
    flush_i       = 1'b0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'h0;
  endtask

  task automatic test_reset();
    rst_i   = 1'b0;
    addr_i  = 32'h0;
    wdata_i = 32'h0;
    idle_inputs();
    next_cycle();
    next_cycle();
    #1;
    n_cmp++; if (stall_o !== 1'b0)     begin n_err++; $display("FAIL reset_stall got=%0h exp=0", stall_o); end
    n_cmp++; if (dmem_req_o !== 1'b0)  begin n_err++; $display("FAIL reset_req got=%0h exp=0", dmem_req_o); end
    n_cmp++; if (dmem_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_addr got=%0h exp=0", dmem_addr_o); end
    n_cmp++; if (rdata_o !== 32'h0)    begin n_err++; $display("FAIL reset_rdata got=%0h exp=0", rdata_o); end
    n_cmp++; if ({rdata_valid_o, err_o, dmem_we_o} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%0b exp=000", {rdata_valid_o, err_o, dmem_we_o}); end
    rst_i = 1'b1;
    next_cycle();
  endtask

  task automatic test_store();
    int stalls = 0;
    mem_valid_i = 1'b1; MemRW_i = 1'b1; addr_i = 32'h100; wdata_i = 32'hDEADBEEF;
    #1;
    n_cmp++; if (stall_o !== 1'b1)    begin n_err++; $display("FAIL store_idle_stall got=%0h exp=1", stall_o); end
    n_cmp++; if (dmem_req_o !== 1'b0) begin n_err++; $display("FAIL store_idle_req got=%0h exp=0", dmem_req_o); end
    stalls += int'(stall_o);
    next_cycle();
    dmem_gnt_i = 1'b1;
    #1;
    n_cmp++; if (dmem_req_o !== 1'b1)      begin n_err++; $display("FAIL store_req got=%0h exp=1", dmem_req_o); end
    n_cmp++; if (dmem_we_o !== 1'b1)       begin n_err++; $display("FAIL store_we got=%0h exp=1", dmem_we_o); end
    n_cmp++; if (dmem_addr_o !== 32'h100)  begin n_err++; $display("FAIL store_addr got=%0h exp=100", dmem_addr_o); end
    n_cmp++; if (dmem_wdata_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL store_wdata got=%0h exp=deadbeef", dmem_wdata_o); end
    stalls += int'(stall_o);
    next_cycle();
    dmem_gnt_i = 1'b0;
    #1;
    n_cmp++; if (stall_o !== 1'b0)       begin n_err++; $display("FAIL store_done_stall got=%0h exp=0", stall_o); end
    n_cmp++; if (dmem_req_o !== 1'b0)    begin n_err++; $display("FAIL store_done_req got=%0h exp=0", dmem_req_o); end
    n_cmp++; if (rdata_valid_o !== 1'b0) begin n_err++; $display("FAIL store_rvld got=%0h exp=0", rdata_valid_o); end
    n_cmp++; if (err_o !== 1'b0)         begin n_err++; $display("FAIL store_err got=%0h exp=0", err_o); end
    n_cmp++; if (stalls !== 2)           begin n_err++; $display("FAIL store_stall_count got=%0d exp=2", stalls); end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_load();
    int stalls = 0;
    int vld = 0;
    mem_valid_i = 1'b1; mem_rd_i = 1'b1; addr_i = 32'h200; wdata_i = 32'h0;
    for (int c = 0; c < 7; c++) begin
      dmem_gnt_i    = (c == 3);
      dmem_rvalid_i = (c == 6);
      dmem_rdata_i  = (c == 6) ? 32'h12345678 : 32'h0;
      #1;
      stalls += int'(stall_o);
      vld    += int'(rdata_valid_o);
      if (c >= 1 && c <= 3) begin
        n_cmp++; if (dmem_req_o !== 1'b1) begin n_err++; $display("FAIL load_req c=%0d got=%0h exp=1", c, dmem_req_o); end
      end
      if (c == 4) begin
        n_cmp++; if (dmem_req_o !== 1'b0) begin n_err++; $display("FAIL load_resp_req got=%0h exp=0", dmem_req_o); end
      end
      next_cycle();
    end
    idle_inputs();
    #1;
    n_cmp++; if (stalls !== 7)              begin n_err++; $display("FAIL load_stall_count got=%0d exp=7", stalls); end
    n_cmp++; if (vld !== 0)                 begin n_err++; $display("FAIL load_early_vld got=%0d exp=0", vld); end
    n_cmp++; if (stall_o !== 1'b0)          begin n_err++; $display("FAIL load_done_stall got=%0h exp=0", stall_o); end
    n_cmp++; if (rdata_valid_o !== 1'b1)    begin n_err++; $display("FAIL load_rvld got=%0h exp=1", rdata_valid_o); end
    n_cmp++; if (rdata_o !== 32'h12345678)  begin n_err++; $display("FAIL load_rdata got=%0h exp=12345678", rdata_o); end
    next_cycle();
    #1;
    n_cmp++; if (rdata_valid_o !== 1'b0)    begin n_err++; $display("FAIL load_rvld_pulse got=%0h exp=0", rdata_valid_o); end
    n_cmp++; if (rdata_o !== 32'h12345678)  begin n_err++; $display("FAIL load_rdata_hold got=%0h exp=12345678", rdata_o); end
    next_cycle();
  endtask

  task automatic test_timeout();
    int reqs = 0;
    int errs = 0;
    mem_valid_i = 1'b1; mem_rd_i = 1'b1; addr_i = 32'h240;
    next_cycle();
    for (int c = 1; c <= 16; c++) begin
      #1;
      reqs += int'(dmem_req_o);
      errs += int'(err_o);
      next_cycle();
    end
    idle_inputs();
    #1;
    n_cmp++; if (reqs !== 16)            begin n_err++; $display("FAIL tmo_req_cycles got=%0d exp=16", reqs); end
    n_cmp++; if (errs !== 0)             begin n_err++; $display("FAIL tmo_early_err got=%0d exp=0", errs); end
    n_cmp++; if (err_o !== 1'b1)         begin n_err++; $display("FAIL tmo_err got=%0h exp=1", err_o); end
    n_cmp++; if (dmem_req_o !== 1'b0)    begin n_err++; $display("FAIL tmo_req_drop got=%0h exp=0", dmem_req_o); end
    n_cmp++; if (stall_o !== 1'b0)       begin n_err++; $display("FAIL tmo_stall got=%0h exp=0", stall_o); end
    n_cmp++; if (rdata_valid_o !== 1'b0) begin n_err++; $display("FAIL tmo_rvld got=%0h exp=0", rdata_valid_o); end
    n_cmp++; if (rdata_o !== 32'h0)      begin n_err++; $display("FAIL tmo_rdata got=%0h exp=0", rdata_o); end
    next_cycle();
    #1;
    n_cmp++; if (err_o !== 1'b0)         begin n_err++; $display("FAIL tmo_err_pulse got=%0h exp=0", err_o); end
    next_cycle();
  endtask

  task automatic test_flush_req();
    mem_valid_i = 1'b1; MemRW_i = 1'b1; addr_i = 32'h300; wdata_i = 32'h55;
    next_cycle();
    flush_i = 1'b1;
    #1;
    n_cmp++; if (dmem_req_o !== 1'b1) begin n_err++; $display("FAIL flreq_req got=%0h exp=1", dmem_req_o); end
    next_cycle();
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if ({dmem_req_o, stall_o, rdata_valid_o, err_o} !== 4'b0000) begin n_err++; $display("FAIL flreq_idle c=%0d got=%0b exp=0000", c, {dmem_req_o, stall_o, rdata_valid_o, err_o}); end
      next_cycle();
    end
  endtask

  task automatic test_flush_resp();
    int vld = 0;
    mem_valid_i = 1'b1; mem_rd_i = 1'b1; addr_i = 32'h400;
    next_cycle();
    dmem_gnt_i = 1'b1;
    next_cycle();
    idle_inputs();
    flush_i = 1'b1;
    #1;
    n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL flresp_stall got=%0h exp=1", stall_o); end
    next_cycle();
    flush_i = 1'b0;
    #1;
    n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL flresp_drain got=%0h exp=1", stall_o); end
    next_cycle();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hAAAA5555;
    next_cycle();
    idle_inputs();
    #1;
    vld += int'(rdata_valid_o);
    n_cmp++; if (stall_o !== 1'b0)  begin n_err++; $display("FAIL flresp_done_stall got=%0h exp=0", stall_o); end
    n_cmp++; if (err_o !== 1'b0)    begin n_err++; $display("FAIL flresp_err got=%0h exp=0", err_o); end
    n_cmp++; if (rdata_o !== 32'h0) begin n_err++; $display("FAIL flresp_rdata got=%0h exp=0", rdata_o); end
    next_cycle();
    #1;
    vld += int'(rdata_valid_o);
    n_cmp++; if (vld !== 0) begin n_err++; $display("FAIL flresp_rvld got=%0d exp=0", vld); end
    next_cycle();
  endtask

  task automatic test_store_priority();
    mem_valid_i = 1'b1; mem_rd_i = 1'b1; MemRW_i = 1'b1; addr_i = 32'h44C; wdata_i = 32'hCAFE0001;
    next_cycle();
    dmem_gnt_i = 1'b1;
    #1;
    n_cmp++; if (dmem_we_o !== 1'b1) begin n_err++; $display("FAIL prio_we got=%0h exp=1", dmem_we_o); end
    next_cycle();
    idle_inputs();
    #1;
    n_cmp++; if ({stall_o, rdata_valid_o} !== 2'b00) begin n_err++; $display("FAIL prio_done got=%0b exp=00", {stall_o, rdata_valid_o}); end
    next_cycle();
  endtask

  task automatic test_reset_mid_resp();
    mem_valid_i = 1'b1; mem_rd_i = 1'b1; addr_i = 32'h500; wdata_i = 32'h77;
    next_cycle();
    dmem_gnt_i = 1'b1;
    next_cycle();
    dmem_gnt_i = 1'b0;
    #1;
    n_cmp++; if ({stall_o, dmem_req_o} !== 2'b10) begin n_err++; $display("FAIL rstm_resp got=%0b exp=10", {stall_o, dmem_req_o}); end
    mem_valid_i = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    n_cmp++; if (stall_o !== 1'b0)      begin n_err++; $display("FAIL rstm_stall got=%0h exp=0", stall_o); end
    n_cmp++; if (dmem_addr_o !== 32'h0) begin n_err++; $display("FAIL rstm_addr got=%0h exp=0", dmem_addr_o); end
    n_cmp++; if (dmem_wdata_o !== 32'h0) begin n_err++; $display("FAIL rstm_wdata got=%0h exp=0", dmem_wdata_o); end
    n_cmp++; if ({dmem_req_o, dmem_we_o, rdata_valid_o, err_o} !== 4'b0000) begin n_err++; $display("FAIL rstm_flags got=%0b exp=0000", {dmem_req_o, dmem_we_o, rdata_valid_o, err_o}); end
    next_cycle();
    rst_i = 1'b1;
    idle_inputs();
    next_cycle();
    mem_valid_i = 1'b1; mem_rd_i = 1'b1; addr_i = 32'h600;
    next_cycle();
    dmem_gnt_i = 1'b1;
    #1;
    n_cmp++; if (dmem_addr_o !== 32'h600) begin n_err++; $display("FAIL rstm_new_addr got=%0h exp=600", dmem_addr_o); end
    next_cycle();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0BADF00D;
    next_cycle();
    idle_inputs();
    #1;
    n_cmp++; if (rdata_valid_o !== 1'b1)   begin n_err++; $display("FAIL rstm_rvld got=%0h exp=1", rdata_valid_o); end
    n_cmp++; if (rdata_o !== 32'h0BADF00D) begin n_err++; $display("FAIL rstm_rdata got=%0h exp=0badf00d", rdata_o); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_timeout();
    test_flush_req();
    test_flush_resp();
    test_store_priority();
    test_reset_mid_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
